serial_rx_param: RTL and testbench

//  Parametrised UART receiver: configurable data width, parity and stop bits, glitch-filtered

---
 rtl/serial_rx_param_pkg.sv | 26 ++
 rtl/serial_rx_fifo.sv | 56 +++++
 rtl/serial_rx_param.sv | 135 +++++++++++++
 tb/tb_serial_rx_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_param_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the UART receiver.
package serial_rx_param_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   // Bits needed to hold values 0..v-1, never less than one bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Synchronous receive FIFO with a registered head word that keeps its last value once drained.
module serial_rx_fifo
   import serial_rx_param_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             drop
);

   localparam int AW   = clog2(DEPTH);
   localparam int CNTW = clog2(DEPTH + 1);
   localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_nx;
   logic [CNTW-1:0]  count, count_nx;
   logic             do_push, do_pop;

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign do_pop   = pop && (count != '0);
   assign do_push  = push && ((count != FULL) || do_pop);
   assign rd_nx    = rd_ptr + AW'(do_pop);
   assign count_nx = count + CNTW'(do_push) - CNTW'(do_pop);
   assign valid    = (count != '0);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
         drop   <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_nx;
         count  <= count_nx;
         drop   <= push && !do_push;
         // New head is the word being written now only when nothing older remains.
         if (count_nx != '0)
            dout <= (do_push && (rd_nx == wr_ptr)) ? din : mem[rd_nx];
      end
   end

endmodule

// File: rtl/serial_rx_param.sv
// UART receiver: synchroniser, 3-sample majority bit sampler, frame FSM and receive FIFO.
module serial_rx_param
   import serial_rx_param_pkg::*;
#(
   parameter int CLKS_PER_BIT = 694,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_perr,
   output logic                 rx_ferr,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = clog2(CLKS_PER_BIT);
   localparam int IW = clog2(DATA_BITS + 1);
   localparam int FW = DATA_BITS + 2;
   localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] SMP_A         = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] SMP_B         = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] SMP_C         = CW'(CLKS_PER_BIT / 2 + 1);
   localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS);
   localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

   rx_state_t            state, state_nx;
   logic                 sync1, rxs;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic                 smp_a, smp_b;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr, ferr;
   logic                 maj, decide, bit_end, push, ferr_fin, par_exp;
   logic [FW-1:0]        head;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx;
         rxs   <= sync1;
      end
   end

   // The third sample is the live synchronised line, so the vote resolves at SMP_C.
   assign decide   = (cnt == SMP_C);
   assign bit_end  = (cnt == CNT_LAST);
   assign maj      = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
   assign ferr_fin = ferr | ~maj;
   assign par_exp  = (PARITY == PARITY_ODD) ? ~(^shreg) : (^shreg);
   assign busy     = (state != ST_IDLE);

   always_comb begin
      state_nx = state;
      push     = 1'b0;
      case (state)
         ST_IDLE:   if (!rxs) state_nx = ST_START;
         ST_START: begin
            if (decide && maj)  state_nx = ST_IDLE;
            else if (bit_end)   state_nx = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end && (idx == IDX_DATA_LAST))
               state_nx = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: if (bit_end) state_nx = ST_STOP;
         // Final stop bit completes the frame at its vote, without waiting for the bit end.
         ST_STOP: begin
            if (decide && (idx == IDX_STOP_LAST)) begin
               push     = 1'b1;
               state_nx = ferr_fin ? ST_BREAK : ST_IDLE;
            end
         end
         ST_BREAK:  if (rxs) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset || (state == ST_IDLE)) cnt <= '0;
      else if (bit_end)                cnt <= '0;
      else                             cnt <= cnt + 1'b1;
   end

   // idx counts data bits in DATA and stop bits in STOP; cleared on every state change.
   always_ff @(posedge clk) begin
      if (reset || (state != state_nx))                          idx <= '0;
      else if (decide && ((state == ST_DATA) || (state == ST_STOP))) idx <= idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (cnt == SMP_A) smp_a <= rxs;
      if (cnt == SMP_B) smp_b <= rxs;
      if ((state == ST_DATA) && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (state == ST_IDLE) begin
         perr <= 1'b0;
         ferr <= 1'b0;
      end else begin
         if ((state == ST_PARITY) && decide) perr <= (maj != par_exp);
         if ((state == ST_STOP) && decide)   ferr <= ferr_fin;
      end
   end

   serial_rx_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   ({perr, ferr_fin, shreg}),
      .pop   (rx_ready),
      .dout  (head),
      .valid (rx_valid),
      .drop  (overrun)
   );

   assign rx_perr = head[FW-1];
   assign rx_ferr = head[FW-2];
   assign rx_data = head[DATA_BITS-1:0];

endmodule

// File: tb/tb_serial_rx_param.sv
// Directed bench: three receiver instances (8N1, 8E1, 8N2) driven with hand-built frames.
module tb_serial_rx_param;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
   logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;

   logic [7:0] data_a, data_b, data_c;
   logic perr_a, perr_b, perr_c, ferr_a, ferr_b, ferr_c;
   logic valid_a, valid_b, valid_c, ovr_a, ovr_b, ovr_c, busy_a, busy_b, busy_c;

   int n_checks = 0;
   int n_errors = 0;
   int ovr_cnt_a = 0;
   logic [9:0] q_a[$];
   logic [9:0] q_b[$];
   logic [9:0] q_c[$];

   always #5 clk = ~clk;

   serial_rx_param #(.CLKS_PER_BIT(CPB)) dut_a (
      .clk(clk), .reset(reset), .rx(rx_a), .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a),
      .rx_valid(valid_a), .rx_ready(rdy_a), .overrun(ovr_a), .busy(busy_a));

   serial_rx_param #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut_b (
      .clk(clk), .reset(reset), .rx(rx_b), .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b),
      .rx_valid(valid_b), .rx_ready(rdy_b), .overrun(ovr_b), .busy(busy_b));

   serial_rx_param #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_c (
      .clk(clk), .reset(reset), .rx(rx_c), .rx_data(data_c), .rx_perr(perr_c), .rx_ferr(ferr_c),
      .rx_valid(valid_c), .rx_ready(rdy_c), .overrun(ovr_c), .busy(busy_c));

   always @(posedge clk) begin
      if (valid_a && rdy_a) q_a.push_back({perr_a, ferr_a, data_a});
      if (valid_b && rdy_b) q_b.push_back({perr_b, ferr_b, data_b});
      if (valid_c && rdy_c) q_c.push_back({perr_c, ferr_c, data_c});
   end

   always @(negedge clk) if (ovr_a) ovr_cnt_a++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] entry(input int d, input int i);
      case (d)
         0:       return (i < q_a.size()) ? q_a[i] : 10'h3ff;
         1:       return (i < q_b.size()) ? q_b[i] : 10'h3ff;
         default: return (i < q_c.size()) ? q_c[i] : 10'h3ff;
      endcase
   endfunction

   task automatic set_line(input int d, input logic v);
      case (d)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   task automatic bit_wait();
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input int d, input logic [7:0] data, input bit has_par,
                             input logic par, input int nstop, input logic [1:0] stops);
      set_line(d, 1'b0);
      bit_wait();
      for (int i = 0; i < 8; i++) begin
         set_line(d, data[i]);
         bit_wait();
      end
      if (has_par) begin
         set_line(d, par);
         bit_wait();
      end
      for (int s = 0; s < nstop; s++) begin
         set_line(d, stops[s]);
         bit_wait();
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_valid", valid_a, 0);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_data", data_a, 0);
      check_eq("rst_overrun", ovr_a, 0);
      check_eq("rst_perr", perr_a, 0);
      check_eq("rst_ferr", ferr_a, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // two clean 8N1 frames
      send_frame(0, 8'h55, 0, 1'b0, 1, 2'b11);
      send_frame(0, 8'hA3, 0, 1'b0, 1, 2'b11);
      repeat (10) @(negedge clk);
      check_eq("t1_count", q_a.size(), 2);
      check_eq("t1_word0", entry(0, 0), 10'h055);
      check_eq("t1_word1", entry(0, 1), 10'h0A3);
      check_eq("t1_overrun", ovr_cnt_a, 0);
      check_eq("t1_valid_after", valid_a, 0);
      check_eq("t1_head_hold", data_a, 8'hA3);

      // start glitch of a quarter bit
      q_a.delete();
      rx_a = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("t2_busy_start", busy_a, 1);
      rx_a = 1'b1;
      repeat (11) @(negedge clk);
      check_eq("t2_busy_drop", busy_a, 0);
      repeat (20) @(negedge clk);
      check_eq("t2_no_push", q_a.size(), 0);
      check_eq("t2_valid", valid_a, 0);

      // even parity: 0x07 needs parity bit 1
      send_frame(1, 8'h07, 1, 1'b0, 1, 2'b11);
      send_frame(1, 8'h07, 1, 1'b1, 1, 2'b11);
      repeat (10) @(negedge clk);
      check_eq("t3_count", q_b.size(), 2);
      check_eq("t3_bad_par", entry(1, 0), 10'h207);
      check_eq("t3_good_par", entry(1, 1), 10'h007);

      // stop bit low, then line held low (break)
      q_a.delete();
      send_frame(0, 8'h5A, 0, 1'b0, 1, 2'b00);
      repeat (3 * CPB) @(negedge clk);
      check_eq("t4_break_busy", busy_a, 1);
      check_eq("t4_break_count", q_a.size(), 1);
      set_line(0, 1'b1);
      repeat (20) @(negedge clk);
      check_eq("t4_break_exit", busy_a, 0);
      check_eq("t4_ferr_word", entry(0, 0), 10'h15A);
      send_frame(0, 8'h33, 0, 1'b0, 1, 2'b11);
      repeat (10) @(negedge clk);
      check_eq("t4_recover_count", q_a.size(), 2);
      check_eq("t4_recover_word", entry(0, 1), 10'h033);

      // two stop bits, second one low
      send_frame(2, 8'h96, 0, 1'b0, 2, 2'b01);
      set_line(2, 1'b1);
      repeat (20) @(negedge clk);
      send_frame(2, 8'h69, 0, 1'b0, 2, 2'b11);
      repeat (10) @(negedge clk);
      check_eq("t4b_count", q_c.size(), 2);
      check_eq("t4b_ferr_word", entry(2, 0), 10'h196);
      check_eq("t4b_good_word", entry(2, 1), 10'h069);

      // overrun: five frames into a four-entry FIFO with no consumer
      rdy_a = 1'b0;
      q_a.delete();
      ovr_cnt_a = 0;
      send_frame(0, 8'h11, 0, 1'b0, 1, 2'b11);
      send_frame(0, 8'h22, 0, 1'b0, 1, 2'b11);
      send_frame(0, 8'h33, 0, 1'b0, 1, 2'b11);
      send_frame(0, 8'h44, 0, 1'b0, 1, 2'b11);
      send_frame(0, 8'h55, 0, 1'b0, 1, 2'b11);
      repeat (10) @(negedge clk);
      check_eq("t5_valid", valid_a, 1);
      check_eq("t5_overrun_cycles", ovr_cnt_a, 1);
      check_eq("t5_head", data_a, 8'h11);
      rdy_a = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("t5_drain_count", q_a.size(), 4);
      check_eq("t5_word0", entry(0, 0), 10'h011);
      check_eq("t5_word1", entry(0, 1), 10'h022);
      check_eq("t5_word2", entry(0, 2), 10'h033);
      check_eq("t5_word3", entry(0, 3), 10'h044);

      // reset in the middle of the data bits of 0x3C
      q_a.delete();
      set_line(0, 1'b0);
      bit_wait();
      set_line(0, 1'b0); bit_wait();
      set_line(0, 1'b0); bit_wait();
      set_line(0, 1'b1); bit_wait();
      check_eq("t6_busy_mid", busy_a, 1);
      rx_a  = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      check_eq("t6_busy_reset", busy_a, 0);
      check_eq("t6_valid_reset", valid_a, 0);
      reset = 1'b0;
      repeat (2 * CPB) @(negedge clk);
      send_frame(0, 8'h81, 0, 1'b0, 1, 2'b11);
      repeat (10) @(negedge clk);
      check_eq("t6_count", q_a.size(), 1);
      check_eq("t6_word", entry(0, 0), 10'h081);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
